// File: rtl/ahb_sram_slave_pkg.sv
// ----------------------------------------------------------------------------
// ahb_sram_slave_pkg : AHB-Lite encodings, slave FSM states and helpers
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package ahb_sram_slave_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;

   localparam logic [1:0] HRESP_OKAY  = 2'b00;
   localparam logic [1:0] HRESP_ERROR = 2'b01;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ERR1 = 2'd2,
      ST_ERR2 = 2'd3
   } ahb_slave_state_e;

   function automatic logic ahb_trans_active(input logic [1:0] trans);
      case (trans)
         HTRANS_NONSEQ, HTRANS_SEQ: return 1'b1;
         HTRANS_IDLE, HTRANS_BUSY:  return 1'b0;
         default:                   return 1'b0;
      endcase
   endfunction

   // Little-endian lane enables; only legal (aligned, size<=word) inputs reach this
   function automatic logic [3:0] ahb_byte_en(input logic [2:0] size, input logic [1:0] off);
      case (size)
         HSIZE_BYTE: return 4'b0001 << off;
         HSIZE_HALF: return off[1] ? 4'b1100 : 4'b0011;
         default:    return 4'b1111;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/ahb_sram_slave_array.sv
// ----------------------------------------------------------------------------
// ahb_sram_slave_array : word SRAM, byte-enable synchronous write, async read
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ahb_sram_slave_array #(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          hclk_i,
   input  logic          we_i,
   input  logic [3:0]    be_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [31:0]   wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] mem_q [DEPTH];

   // Contents are deliberately not reset
   always_ff @(posedge hclk_i) begin
      if (we_i) begin
         for (int b = 0; b < 4; b++) begin
            if (be_i[b]) begin
               mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
         end
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/ahb_sram_slave.sv
// ----------------------------------------------------------------------------
// ahb_sram_slave : AHB-Lite SRAM slave with wait states and 2-cycle ERROR
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ahb_sram_slave
   import ahb_sram_slave_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int MEM_DEPTH   = 256,
   parameter int WAIT_STATES = 0
) (
   input  logic                  hclk,
   input  logic                  hresetn,
   input  logic                  hselx,
   input  logic [ADDR_WIDTH-1:0] haddr,
   input  logic [1:0]            htrans,
   input  logic                  hwrite,
   input  logic [2:0]            hsize,
   input  logic [2:0]            hburst,
   input  logic [3:0]            hprot,
   input  logic                  hmastlock,
   input  logic                  hready,
   input  logic [DATA_WIDTH-1:0] hwdata,
   output logic                  hreadyout,
   output logic [1:0]            hresp,
   output logic [DATA_WIDTH-1:0] hrdata
);

   localparam int         c_WAW     = $clog2(MEM_DEPTH);
   localparam int         c_LAW     = c_WAW + 2;
   localparam logic [3:0] c_WS      = 4'(WAIT_STATES);
   localparam logic       c_WS_ZERO = (WAIT_STATES == 0);

   ahb_slave_state_e state_q;
   logic [3:0]       cnt_q;
   logic [c_LAW-1:0] addr_q;
   logic             write_q;
   logic [2:0]       size_q;
   logic             hreadyout_q;
   logic [1:0]       hresp_q;
   logic             rd_valid_q;

   logic        accept;
   logic        misalign;
   logic        out_of_range;
   logic        err;
   logic        we;
   logic [31:0] rdata;
   logic        unused_ok;

   assign unused_ok = ^{hburst, hprot, hmastlock};

   // hreadyout_q gate keeps a misbehaving interconnect from overlapping phases
   assign accept       = hselx && hready && ahb_trans_active(htrans) && hreadyout_q;
   assign misalign     = ((hsize == HSIZE_HALF) && haddr[0]) ||
                         ((hsize == HSIZE_WORD) && (haddr[1:0] != 2'b00));
   assign out_of_range = |(haddr >> c_LAW);
   assign err          = (hsize > HSIZE_WORD) || misalign || out_of_range;

   assign we = (state_q == ST_WAIT) && (cnt_q == 4'd0) && write_q;

   ahb_sram_slave_array #(
      .DEPTH (MEM_DEPTH)
   ) u_array (
      .hclk_i  (hclk),
      .we_i    (we),
      .be_i    (ahb_byte_en(size_q, addr_q[1:0])),
      .waddr_i (addr_q[c_LAW-1:2]),
      .wdata_i (hwdata),
      .raddr_i (addr_q[c_LAW-1:2]),
      .rdata_o (rdata)
   );

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 4'd0;
         addr_q      <= '0;
         write_q     <= 1'b0;
         size_q      <= 3'd0;
         hreadyout_q <= 1'b1;
         hresp_q     <= HRESP_OKAY;
         rd_valid_q  <= 1'b0;
      end else if (accept) begin
         addr_q  <= haddr[c_LAW-1:0];
         write_q <= hwrite;
         size_q  <= hsize;
         if (err) begin
            state_q     <= ST_ERR1;
            hreadyout_q <= 1'b0;
            hresp_q     <= HRESP_ERROR;
            rd_valid_q  <= 1'b0;
         end else begin
            state_q     <= ST_WAIT;
            cnt_q       <= c_WS;
            hreadyout_q <= c_WS_ZERO;
            hresp_q     <= HRESP_OKAY;
            rd_valid_q  <= !hwrite && c_WS_ZERO;
         end
      end else begin
         unique case (state_q)
            ST_WAIT: begin
               if (cnt_q != 4'd0) begin
                  cnt_q <= cnt_q - 4'd1;
                  // Last wait cycle: next cycle completes the data phase
                  if (cnt_q == 4'd1) begin
                     hreadyout_q <= 1'b1;
                     rd_valid_q  <= !write_q;
                  end
               end else begin
                  state_q    <= ST_IDLE;
                  rd_valid_q <= 1'b0;
               end
            end
            ST_ERR1: begin
               state_q     <= ST_ERR2;
               hreadyout_q <= 1'b1;
            end
            ST_ERR2: begin
               state_q <= ST_IDLE;
               hresp_q <= HRESP_OKAY;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign hreadyout = hreadyout_q;
   assign hresp     = hresp_q;
   assign hrdata    = rd_valid_q ? rdata : '0;

endmodule

`default_nettype wire
